// File: rtl/pic_sram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pic_sram_pkg : FSM state encoding and default picture geometry shared    |
// |                by the picture SRAM writer and reader.                    |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package pic_sram_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_READ  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } pic_state_t;

  localparam logic [7:0] C_START_ADDR = 8'd0;
  localparam int         C_AW         = 8;
  localparam int         C_DW         = 128;
  localparam int         C_PIC_SIZE   = 256;

endpackage
`default_nettype wire

// File: rtl/pic_rd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pic_rd_fifo : small synchronous FIFO holding returned SRAM words until   |
// |               the stream consumer takes them. dout is zero when empty.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module pic_rd_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  logic [DW-1:0]                din,
  input  logic                         pop,
  output logic [DW-1:0]                dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;
  logic [CNTW-1:0] count_q;
  logic            pop_en;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign pop_en = pop & ~empty;
  assign count  = count_q;
  assign dout   = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wptr_q] <= din;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop_en) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (push && !pop_en) begin
        count_q <= count_q + CNTW'(1);
      end else if (!push && pop_en) begin
        count_q <= count_q - CNTW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_pic_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_pic_reader : streams one picture out of a synchronous-read SRAM     |
// |                   onto a valid/ready stream with first/last markers.     |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module sram_pic_reader
  import pic_sram_pkg::*;
#(
  parameter int            AW           = C_AW,
  parameter int            DW           = C_DW,
  parameter logic [AW-1:0] P_START_ADDR = AW'(C_START_ADDR),
  parameter int            P_PIC_SIZE   = C_PIC_SIZE,
  parameter int            P_RD_LAT     = 1,
  parameter int            P_FIFO_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          rsram_sop,
  output logic          busy,
  output logic          sram_ren,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rdata,
  output logic [DW-1:0] rd_data,
  output logic          rd_vld,
  input  logic          rd_ready,
  output logic          rd_first,
  output logic          rd_last,
  output logic          done
);

  localparam int CW  = $clog2(P_PIC_SIZE) + 1;
  localparam int FCW = $clog2(P_FIFO_DEPTH + 1);

  pic_state_t          state_q;
  logic [CW-1:0]       issue_idx_q;
  logic [CW-1:0]       beat_q;
  logic                sram_ren_q;
  logic [AW-1:0]       sram_raddr_q;
  logic [P_RD_LAT-1:0] pipe_q;
  logic                busy_q;
  logic                done_q;

  logic [AW-1:0]       raddr_d;
  logic [FCW-1:0]      fifo_count;
  logic                fifo_empty;
  logic                sop_accept;
  logic                issue;
  logic                xfer;
  int                  credit_used;

  // Every read between issue and consumption holds a FIFO credit.
  always_comb begin
    credit_used = int'(fifo_count) + int'(sram_ren_q);
    for (int i = 0; i < P_RD_LAT; i++) begin
      credit_used = credit_used + int'(pipe_q[i]);
    end
  end

  assign sop_accept = (state_q == ST_IDLE) && rsram_sop;
  assign issue      = sop_accept ||
                      ((state_q == ST_READ) && (issue_idx_q < CW'(P_PIC_SIZE)) &&
                       (credit_used < P_FIFO_DEPTH));
  assign raddr_d    = sop_accept ? P_START_ADDR : P_START_ADDR + AW'(issue_idx_q);
  assign xfer       = rd_vld & rd_ready;

  assign busy       = busy_q;
  assign sram_ren   = sram_ren_q;
  assign sram_raddr = sram_raddr_q;
  assign done       = done_q;
  assign rd_vld     = ~fifo_empty;
  assign rd_first   = rd_vld && (beat_q == '0);
  assign rd_last    = rd_vld && (beat_q == CW'(P_PIC_SIZE - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      issue_idx_q  <= '0;
      beat_q       <= '0;
      sram_ren_q   <= 1'b0;
      sram_raddr_q <= '0;
      pipe_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sram_ren_q <= issue;
      if (issue) begin
        sram_raddr_q <= raddr_d;
      end
      pipe_q[0] <= sram_ren_q;
      for (int i = 1; i < P_RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (xfer) begin
        beat_q <= beat_q + CW'(1);
      end
      done_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          // Word 0 is issued on the sop edge itself, so the index starts past it.
          if (rsram_sop) begin
            state_q     <= ST_READ;
            issue_idx_q <= CW'(1);
            beat_q      <= '0;
            busy_q      <= 1'b1;
          end
        end
        ST_READ: begin
          if (issue) begin
            issue_idx_q <= issue_idx_q + CW'(1);
          end
          if (issue_idx_q == CW'(P_PIC_SIZE)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (xfer && rd_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pic_rd_fifo #(
    .DW    (DW),
    .DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (pipe_q[P_RD_LAT-1]),
    .din   (sram_rdata),
    .pop   (rd_ready),
    .dout  (rd_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_pic_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_pic_reader : four reader instances (default, latency 3, start    |
// |                      F0, one-word picture) against an arithmetic model.  |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_sram_pic_reader;

  localparam int NDUT  = 4;
  localparam int DW    = 128;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  function automatic int f_lat(input int i);
    return (i == 1) ? 3 : 1;
  endfunction
  function automatic int f_start(input int i);
    return (i == 2) ? 32'hF0 : 0;
  endfunction
  function automatic int f_size(input int i);
    return (i == 3) ? 1 : 256;
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic          sop_s   [NDUT];
  logic          ready_s [NDUT];
  logic          busy_s  [NDUT];
  logic          ren_s   [NDUT];
  logic          vld_s   [NDUT];
  logic          first_s [NDUT];
  logic          last_s  [NDUT];
  logic          done_s  [NDUT];
  logic [AW-1:0] raddr_s [NDUT];
  logic [DW-1:0] rdata_s [NDUT];
  logic [DW-1:0] data_s  [NDUT];

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {16{b}};
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT   = f_lat(g);
    localparam int START = f_start(g);
    localparam int SIZE  = f_size(g);
    logic [DW-1:0] mem_pipe [3];
    int n_beats = 0;
    int n_iss   = 0;
    int n_done  = 0;

    sram_pic_reader #(
      .AW           (AW),
      .DW           (DW),
      .P_START_ADDR (AW'(START)),
      .P_PIC_SIZE   (SIZE),
      .P_RD_LAT     (LAT),
      .P_FIFO_DEPTH (DEPTH)
    ) u_dut (
      .CLK        (clk),
      .RST        (rst),
      .rsram_sop  (sop_s[g]),
      .busy       (busy_s[g]),
      .sram_ren   (ren_s[g]),
      .sram_raddr (raddr_s[g]),
      .sram_rdata (rdata_s[g]),
      .rd_data    (data_s[g]),
      .rd_vld     (vld_s[g]),
      .rd_ready   (ready_s[g]),
      .rd_first   (first_s[g]),
      .rd_last    (last_s[g]),
      .done       (done_s[g])
    );

    // SRAM model: garbage except exactly LAT cycles after a read enable.
    always @(posedge clk) begin
      mem_pipe[0] <= ren_s[g] ? word_of(int'(raddr_s[g])) : {$urandom, $urandom, $urandom, $urandom};
      mem_pipe[1] <= mem_pipe[0];
      mem_pipe[2] <= mem_pipe[1];
    end
    assign rdata_s[g] = mem_pipe[LAT-1];

    always @(negedge clk) begin
      if (rst) begin
        n_beats = 0;
        n_iss   = 0;
        n_done  = 0;
      end else begin
        if (sop_s[g] && !busy_s[g]) begin
          n_beats = 0;
          n_iss   = 0;
          n_done  = 0;
        end
        if (ren_s[g]) begin
          check("raddr", DW'(raddr_s[g]), DW'((START + n_iss) % 256));
          check("issue_bound", DW'(n_iss < SIZE), DW'(1));
          n_iss++;
        end
        if (vld_s[g]) begin
          check("rd_data", data_s[g], word_of(START + n_beats));
          check("rd_first", DW'(first_s[g]), DW'(n_beats == 0));
          check("rd_last", DW'(last_s[g]), DW'(n_beats == SIZE - 1));
          if (ready_s[g]) n_beats++;
        end
        if (done_s[g]) begin
          check("done_after_last", DW'(n_beats), DW'(SIZE));
          n_done++;
        end
        check("credit", DW'((n_iss - n_beats) <= DEPTH), DW'(1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sop(input int i);
    sop_s[i] = 1'b1;
    tick();
    sop_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input bit rnd, output int cnt);
    cnt = 0;
    while (!done_s[i] && cnt < budget) begin
      if (rnd) ready_s[i] = 1'($urandom_range(0, 1));
      tick();
      cnt++;
    end
    check("done_seen", DW'(done_s[i]), DW'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      sop_s[i]   = 1'b0;
      ready_s[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", DW'({busy_s[0], ren_s[0], vld_s[0], first_s[0], last_s[0], done_s[0]}), '0);
    check("rst_addr", DW'(raddr_s[0]), '0);
    check("rst_data", data_s[0], '0);
    rst = 1'b0;
    tick();
    tick();

    // Latency, contiguous stream, single done
    pulse_sop(0);
    check("t1_ren_lat", DW'(ren_s[0]), DW'(1));
    check("t1_addr0", DW'(raddr_s[0]), DW'(0));
    check("t1_busy", DW'(busy_s[0]), DW'(1));
    check("t1_vld_n1", DW'(vld_s[0]), DW'(0));
    tick();
    check("t1_vld_n2", DW'(vld_s[0]), DW'(0));
    tick();
    check("t1_first_beat", DW'({vld_s[0], first_s[0]}), DW'(2'b11));
    check("t1_data0", data_s[0], word_of(0));
    wait_done(0, 400, 1'b0, n);
    check("t1_done_cycle", DW'(n), DW'(256));
    check("t1_busy_at_done", DW'(busy_s[0]), DW'(1));
    tick();
    check("t1_busy_drop", DW'({busy_s[0], done_s[0]}), DW'(0));
    repeat (3) tick();
    check("t1_beats", DW'(g_dut[0].n_beats), DW'(256));
    check("t1_dones", DW'(g_dut[0].n_done), DW'(1));

    // Backpressure from the first word on
    ready_s[0] = 1'b0;
    pulse_sop(0);
    repeat (40) tick();
    check("t3_issued", DW'(g_dut[0].n_iss), DW'(4));
    check("t3_ren_idle", DW'(ren_s[0]), DW'(0));
    check("t3_vld_held", DW'(vld_s[0]), DW'(1));
    ready_s[0] = 1'b1;
    wait_done(0, 600, 1'b0, n);
    tick();
    check("t3_beats", DW'(g_dut[0].n_beats), DW'(256));
    check("t3_dones", DW'(g_dut[0].n_done), DW'(1));

    // sop while busy is ignored
    pulse_sop(0);
    repeat (20) tick();
    pulse_sop(0);
    wait_done(0, 600, 1'b0, n);
    pulse_sop(0);
    repeat (10) tick();
    check("t4_issued", DW'(g_dut[0].n_iss), DW'(256));
    check("t4_beats", DW'(g_dut[0].n_beats), DW'(256));
    check("t4_dones", DW'(g_dut[0].n_done), DW'(1));
    check("t4_idle", DW'({busy_s[0], ren_s[0]}), DW'(0));

    // Random backpressure, read latency 3
    pulse_sop(1);
    wait_done(1, 5000, 1'b1, n);
    ready_s[1] = 1'b1;
    tick();
    check("t2_beats", DW'(g_dut[1].n_beats), DW'(256));
    check("t2_dones", DW'(g_dut[1].n_done), DW'(1));

    // Address wrap from F0
    pulse_sop(2);
    check("t5_addr_first", DW'(raddr_s[2]), DW'(8'hF0));
    wait_done(2, 400, 1'b0, n);
    tick();
    check("t5_beats", DW'(g_dut[2].n_beats), DW'(256));
    check("t5_dones", DW'(g_dut[2].n_done), DW'(1));

    // One-word picture
    pulse_sop(3);
    tick();
    tick();
    check("t7_first_last", DW'({vld_s[3], first_s[3], last_s[3]}), DW'(3'b111));
    wait_done(3, 20, 1'b0, n);
    check("t7_done_cycle", DW'(n), DW'(1));
    tick();
    check("t7_beats", DW'(g_dut[3].n_beats), DW'(1));

    // Reset mid-picture, then clean restart
    pulse_sop(0);
    n = 0;
    while (g_dut[0].n_beats < 100 && n < 400) begin
      tick();
      n++;
    end
    check("t6_reached_100", DW'(g_dut[0].n_beats), DW'(100));
    rst = 1'b1;
    #1;
    check("t6_rst_ctrl", DW'({busy_s[0], ren_s[0], vld_s[0], first_s[0], last_s[0], done_s[0]}), '0);
    check("t6_rst_addr", DW'(raddr_s[0]), '0);
    check("t6_rst_data", data_s[0], '0);
    tick();
    rst = 1'b0;
    tick();
    pulse_sop(0);
    check("t6_restart_addr", DW'({ren_s[0], raddr_s[0]}), DW'({1'b1, 8'h00}));
    tick();
    tick();
    check("t6_restart_first", DW'({vld_s[0], first_s[0]}), DW'(2'b11));
    check("t6_restart_data", data_s[0], word_of(0));
    wait_done(0, 400, 1'b0, n);
    tick();
    check("t6_beats", DW'(g_dut[0].n_beats), DW'(256));
    check("t6_dones", DW'(g_dut[0].n_done), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
